serial_ripple_subtractor: RTL and testbench



---
 rtl/serial_ripple_subtractor.sv | 111 +++++++++++
 tb/tb_serial_ripple_subtractor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flop; start/busy/done handshake.
module serial_ripple_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             dbg_state
);

   // Handshake: start is taken only in IDLE (busy=0), including the done cycle;
   // done pulses for one cycle exactly when diff/borrow take a new result.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_br;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;

   logic             w_load;
   logic             w_last;
   logic             w_d;
   logic             w_br_next;

   // Full-subtractor cell on the current LSBs of the operand shift registers.
   assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
   assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load       = 1'b1;
               w_state_next = RUN;
            end
         end
         RUN: begin
            if (r_cnt == LAST) begin
               w_last       = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_br     <= 1'b0;
         r_done   <= 1'b0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= w_last;
         if (w_load) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
            r_res <= '0;
         end else if (r_state == RUN) begin
            // Result fills from the top so the first bit lands at bit 0 after WIDTH shifts.
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_br  <= w_br_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
               r_diff   <= {w_d, r_res[WIDTH-1:1]};
               r_borrow <= w_br_next;
            end
         end
      end
   end

   assign busy      = (r_state == RUN);
   assign done      = r_done;
   assign diff      = r_diff;
   assign borrow    = r_borrow;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed bench for serial_ripple_subtractor (WIDTH=4): latency, handshake,
// reset abort and an exhaustive sweep in shuffled order.
module tb_serial_ripple_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             dbg_state;

  int checks = 0;
  int errors = 0;

  // last result the bench expects to be visible on diff/borrow
  logic [WIDTH-1:0] prev_diff = '0;
  logic             prev_borrow = 1'b0;

  serial_ripple_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow    (borrow),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to done. With disturb set, a second start
  // and operand changes are injected while the first operation is in flight.
  task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic tbin, input logic [3:0] ed, input logic eb,
                        input bit disturb);
    int n;
    int busy_cycles;
    bit got;
    n = 0;
    busy_cycles = 0;
    got = 1'b0;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (disturb && n == 2) begin
        start = 1'b1; a = 4'h0; b = 4'hF; bin = 1'b1;
      end
      if (disturb && n == 3) begin
        start = 1'b0; a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
      end
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cycles++;
        if (diff !== prev_diff || borrow !== prev_borrow)
          chk({tag, "_hold"}, 32'({borrow, diff}), 32'({prev_borrow, prev_diff}));
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(WIDTH + 1));
    chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(WIDTH));
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
    prev_diff = ed;
    prev_borrow = eb;
  endtask

  initial begin
    int n;
    int dones;
    int off;
    logic [3:0] sa, sb, sd;
    logic sbin, sbo;
    logic [4:0] model;

    // reset for two cycles
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);

    // idle with start low: nothing moves
    a = 4'hA; b = 4'h3; bin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_hold", 32'({busy, done, borrow, diff}), 32'd0);
    end

    // directed vectors
    run_op("op_5m3",   4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0);
    run_op("op_0m1",   4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0);
    run_op("op_9m7b",  4'b1001, 4'b0111, 1'b1, 4'b0001, 1'b0, 1'b0);
    run_op("op_7m7b",  4'b0111, 4'b0111, 1'b1, 4'b1111, 1'b1, 1'b0);

    // start while busy is ignored, operand changes mid-run have no effect
    run_op("op_ignore", 4'b1100, 4'b0100, 1'b0, 4'b1000, 1'b0, 1'b1);
    @(negedge clk);
    chk("ignore_not_queued", 32'(busy), 32'd0);

    // start held high: back-to-back operations every WIDTH+1 cycles
    a = 4'b1010; b = 4'b0101; bin = 1'b0; start = 1'b1;
    dones = 0;
    for (n = 1; n <= 15; n++) begin
      @(negedge clk);
      chk("b2b_done", 32'(done), 32'(n % 5 == 0));
      chk("b2b_busy", 32'(busy), 32'(n % 5 != 0));
      if (done) begin
        dones++;
        chk("b2b_diff", 32'({borrow, diff}), 32'({1'b0, 4'b0101}));
      end
      if (n == 15) start = 1'b0;
    end
    chk("b2b_count", 32'(dones), 32'd3);
    @(negedge clk);
    chk("b2b_stop", 32'({busy, done}), 32'd0);
    prev_diff = 4'b0101;
    prev_borrow = 1'b0;

    // reset at the second RUN cycle aborts the operation
    a = 4'b1111; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_run1", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", 32'({busy, done, borrow, diff}), 32'd0);
    prev_diff = '0;
    prev_borrow = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'({busy, done, borrow, diff}), 32'd0);
    end
    run_op("op_after_abort", 4'b1111, 4'b0001, 1'b0, 4'b1110, 1'b0, 1'b0);

    // all 512 (a, b, bin) combinations, shuffled by an odd stride
    off = $urandom_range(0, 511);
    for (int i = 0; i < 512; i++) begin
      int idx;
      idx = (i * 197 + off) % 512;
      sa = 4'(idx >> 5);
      sb = 4'(idx >> 1);
      sbin = idx[0];
      model = {1'b0, sa} - {1'b0, sb} - {4'b0, sbin};
      sd = model[3:0];
      sbo = model[4];
      run_op("sweep", sa, sb, sbin, sd, sbo, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
